// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: size codes, FSM states and alignment helpers for the load/store unit
package mem_access_unit_pkg;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    return size == SIZE_B ? 8'h01 : size == SIZE_H ? 8'h03 : size == SIZE_W ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] ofs);
    return size == SIZE_H ? ofs[0] : size == SIZE_W ? |ofs[1:0] : size == SIZE_D ? |ofs : 1'b0;
  endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/address-ok/data-ok memory bus
interface mem_access_unit_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic req, we, addr_ok, data_ok;
  logic [2:0] size;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  modport master(output req, we, size, addr, wstrb, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, we, size, addr, wstrb, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_access_unit_align.sv
// mem_access_unit_align: store lane steering and load extraction/extension
module mem_access_unit_align
  import mem_access_unit_pkg::*;
#(parameter int DATA_WIDTH = 32) (
  input  logic                            write,
  input  logic                            sign_ext,
  input  logic [1:0]                      size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] ofs,
  input  logic [DATA_WIDTH-1:0]           wdata,
  input  logic [DATA_WIDTH-1:0]           rdata,
  output logic [DATA_WIDTH/8-1:0]         wstrb,
  output logic [DATA_WIDTH-1:0]           wdata_sh,
  output logic [DATA_WIDTH-1:0]           rdata_ext
);
  localparam int LANES = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] sh, keep;
  logic msb;
  always_comb begin
    wstrb = write ? LANES'(size_mask(size)) << ofs : '0;
    wdata_sh = wdata << {ofs, 3'b000};
    sh = rdata >> {ofs, 3'b000};
    keep = size == SIZE_B ? DATA_WIDTH'(8'hFF) : size == SIZE_H ? DATA_WIDTH'(16'hFFFF) :
           size == SIZE_W ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
    msb = size == SIZE_B ? sh[7] : size == SIZE_H ? sh[15] : size == SIZE_W ? sh[31] : sh[DATA_WIDTH-1];
    rdata_ext = (sh & keep) | (sign_ext & msb ? ~keep : '0);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM-stage load/store unit with bus handshake, stall and flush drain
module mem_access_unit
  import mem_access_unit_pkg::*;
#(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic                  req_sign_ext_i,
  input  logic [1:0]            req_size_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic [ADDR_WIDTH-1:0] badvaddr_o,
  mem_access_unit_if.master     bus
);
  localparam int OFS_W = $clog2(DATA_WIDTH / 8);
  state_t state, next;
  logic [1:0] size_in, r_size;
  logic mis, accept, capture, r_write, r_sign;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, load_val;
  // a dword on a 32-bit bus is handled as a word
  assign size_in = (DATA_WIDTH == 32 && req_size_i == SIZE_D) ? SIZE_W : req_size_i;
  assign mis = misaligned(size_in, 3'(req_addr_i[OFS_W-1:0]));
  assign adel_o = req_valid_i & mis & !req_write_i;
  assign ades_o = req_valid_i & mis & req_write_i;
  assign badvaddr_o = adel_o | ades_o ? req_addr_i : '0;
  assign accept = req_valid_i & !flush & !mis;
  assign capture = !r_write & !flush & bus.data_ok & (state == DATA | (state == ADDR & bus.addr_ok));
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:  next = accept ? ADDR : IDLE;
      ADDR:  next = !bus.addr_ok ? (flush ? IDLE : ADDR) :
                    bus.data_ok ? (flush ? IDLE : DONE) : (flush ? DRAIN : DATA);
      DATA:  next = bus.data_ok ? (flush ? IDLE : DONE) : (flush ? DRAIN : DATA);
      DONE:  next = IDLE;
      DRAIN: next = bus.data_ok ? IDLE : DRAIN;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.req = state == ADDR;
    done_o = state == DONE;
    stall_o = !flush & ((state == IDLE & accept) | state == ADDR | state == DATA |
                        (state == DRAIN & req_valid_i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_sign <= 1'b0;
      r_size <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      rdata_o <= '0;
    end else begin
      if (state == IDLE && accept) begin
        r_write <= req_write_i;
        r_sign <= req_sign_ext_i;
        r_size <= size_in;
        r_addr <= req_addr_i;
        r_wdata <= req_wdata_i;
      end
      if (capture) rdata_o <= load_val;
    end
  end
  assign bus.we = r_write;
  assign bus.size = {1'b0, r_size};
  assign bus.addr = r_addr;
  mem_access_unit_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .write(r_write),
    .sign_ext(r_sign),
    .size(r_size),
    .ofs(r_addr[OFS_W-1:0]),
    .wdata(r_wdata),
    .rdata(bus.rdata),
    .wstrb(bus.wstrb),
    .wdata_sh(bus.wdata),
    .rdata_ext(load_val)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table, randomized model check and flush/reset sequences for 32- and 64-bit units
module tb_mem_access_unit;
  logic clk = 0, rst = 1, rst64 = 1;
  always #5 clk = ~clk;
  logic flush = 0, rv = 0, rw = 0, rse = 0;
  logic [1:0] rsz = 0;
  logic [31:0] ra = 0, rwd = 0, rdo, badv;
  logic stall, done, adel, ades;
  logic flush64 = 0, v64 = 0, w64 = 0, s64 = 0;
  logic [1:0] sz64 = 0;
  logic [31:0] a64 = 0, badv64;
  logic [63:0] wd64 = 0, rdo64;
  logic stall64, done64, adel64, ades64;
  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b32();
  mem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) b64();
  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .req_valid_i(rv), .req_write_i(rw), .req_sign_ext_i(rse),
    .req_size_i(rsz), .req_addr_i(ra), .req_wdata_i(rwd), .stall_o(stall), .done_o(done),
    .rdata_o(rdo), .adel_o(adel), .ades_o(ades), .badvaddr_o(badv), .bus(b32.master));
  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) u64 (
    .clk(clk), .rst(rst64), .flush(flush64), .req_valid_i(v64), .req_write_i(w64), .req_sign_ext_i(s64),
    .req_size_i(sz64), .req_addr_i(a64), .req_wdata_i(wd64), .stall_o(stall64), .done_o(done64),
    .rdata_o(rdo64), .adel_o(adel64), .ades_o(ades64), .badvaddr_o(badv64), .bus(b64.master));

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic w, se;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    int ao, dd;
    logic [3:0] es;
    logic [31:0] ewd, erd;
    logic mis;
  } vec_t;
  vec_t tbl[11];

  // reference: byte count n, byte offset, arithmetic shifts and two's-complement wrap
  function automatic void model(input logic w, input logic se, input logic [1:0] sz,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                                output logic [3:0] es, output logic [31:0] ewd, output logic [31:0] erd,
                                output logic mis);
    int n, ofs;
    longint unsigned v;
    n = 1 << sz;
    ofs = int'(a % 4);
    mis = (a % n) != 0;
    es = w ? 4'(((1 << n) - 1) << ofs) : 4'h0;
    ewd = 32'(64'(wd) << (8 * ofs));
    v = (64'(rd) >> (8 * ofs)) & ((64'h1 << (8 * n)) - 1);
    if (se && ((v >> (8 * n - 1)) & 1) == 1) v = v - (64'h1 << (8 * n));
    erd = 32'(v);
  endfunction

  task automatic run32(input vec_t t, input string tag);
    rv = 1; rw = t.w; rse = t.se; rsz = t.sz; ra = t.a; rwd = t.wd;
    #1;
    chk({tag, " adel"}, adel, t.mis & !t.w);
    chk({tag, " ades"}, ades, t.mis & t.w);
    chk({tag, " badv"}, badv, t.mis ? t.a : 32'h0);
    chk({tag, " accept stall"}, stall, !t.mis);
    if (t.mis) begin
      tick;
      chk({tag, " mis req"}, b32.req, 0);
      rv = 0;
      #1;
      return;
    end
    tick;
    rv = 0;
    #1;
    for (int i = 0; i <= t.ao; i++) begin
      chk({tag, " req"}, b32.req, 1);
      chk({tag, " we"}, b32.we, t.w);
      chk({tag, " size"}, b32.size, {1'b0, t.sz});
      chk({tag, " addr"}, b32.addr, t.a);
      chk({tag, " wstrb"}, b32.wstrb, t.es);
      chk({tag, " wdata"}, b32.wdata, t.ewd);
      chk({tag, " addr stall"}, stall, 1);
      if (i == t.ao) begin
        b32.addr_ok = 1;
        if (t.dd == 0) begin b32.data_ok = 1; b32.rdata = t.rd; end
      end
      tick;
      b32.addr_ok = 0; b32.data_ok = 0; b32.rdata = $urandom;
      #1;
    end
    for (int i = 1; i <= t.dd; i++) begin
      chk({tag, " data req"}, b32.req, 0);
      chk({tag, " data stall"}, stall, 1);
      chk({tag, " data done"}, done, 0);
      if (i == t.dd) begin b32.data_ok = 1; b32.rdata = t.rd; end
      tick;
      b32.data_ok = 0; b32.rdata = $urandom;
      #1;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " done stall"}, stall, 0);
    if (!t.w) chk({tag, " rdata"}, rdo, t.erd);
    tick;
    chk({tag, " done clr"}, done, 0);
  endtask

  task automatic run64(input logic w, input logic se, input logic [1:0] sz, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [7:0] es,
                       input logic [63:0] ewd, input logic [63:0] erd, input string tag);
    v64 = 1; w64 = w; s64 = se; sz64 = sz; a64 = a; wd64 = wd;
    #1;
    chk({tag, " stall"}, stall64, 1);
    tick;
    v64 = 0;
    #1;
    chk({tag, " req"}, b64.req, 1);
    chk({tag, " wstrb"}, b64.wstrb, es);
    chk({tag, " wdata"}, b64.wdata, ewd);
    b64.addr_ok = 1;
    tick;
    b64.addr_ok = 0; b64.data_ok = 1; b64.rdata = rd;
    tick;
    b64.data_ok = 0;
    #1;
    chk({tag, " done"}, done64, 1);
    if (!w) chk({tag, " rdata"}, rdo64, erd);
    tick;
  endtask

  initial begin
    vec_t r;
    b32.addr_ok = 0; b32.data_ok = 0; b32.rdata = 0;
    b64.addr_ok = 0; b64.data_ok = 0; b64.rdata = 0;
    tbl[0]  = '{1'b0, 1'b1, 2'd0, 32'h103,  32'h0,        32'h8000_0000, 0, 2, 4'h0, 32'h0,        32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 32'h202,  32'h0000_ABCD, 32'h0,        2, 1, 4'hC, 32'hABCD_0000, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd2, 32'h1001, 32'h0,        32'h0,         0, 0, 4'h0, 32'h0,        32'h0,         1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, 32'h1002, 32'h0,        32'h0,         0, 0, 4'h0, 32'h0,        32'h0,         1'b1};
    tbl[4]  = '{1'b0, 1'b0, 2'd1, 32'h2,    32'h0,        32'hF00D_0000, 0, 0, 4'h0, 32'h0,        32'h0000_F00D, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 32'h3,    32'h0000_005A, 32'h0,        1, 0, 4'h8, 32'h5A00_0000, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'd1, 32'h0,    32'h0,        32'h1234_8001, 0, 1, 4'h0, 32'h0,        32'hFFFF_8001, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 2'd2, 32'h4,    32'h0,        32'hDEAD_BEEF, 1, 3, 4'h0, 32'h0,        32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h101,  32'h0000_00FF, 32'h0000_9C00, 0, 1, 4'h0, 32'h0000_FF00, 32'h0000_009C, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 32'h8,    32'h1122_3344, 32'h0,        0, 0, 4'hF, 32'h1122_3344, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 1'b0, 2'd1, 32'h3,    32'h0,        32'h0,         0, 0, 4'h0, 32'h0,        32'h0,         1'b1};
    repeat (3) tick;
    chk("rst req", b32.req, 0);
    chk("rst we", b32.we, 0);
    chk("rst size", b32.size, 0);
    chk("rst addr", b32.addr, 0);
    chk("rst wstrb", b32.wstrb, 0);
    chk("rst wdata", b32.wdata, 0);
    chk("rst done", done, 0);
    chk("rst stall", stall, 0);
    chk("rst rdata", rdo, 0);
    rst = 0; rst64 = 0;
    tick;
    foreach (tbl[i]) run32(tbl[i], $sformatf("vec%0d", i));
    for (int k = 0; k < 40; k++) begin
      r.w = 1'($urandom_range(0, 1)); r.se = 1'($urandom_range(0, 1)); r.sz = 2'($urandom_range(0, 2));
      r.a = $urandom; r.wd = $urandom; r.rd = $urandom;
      r.ao = $urandom_range(0, 2); r.dd = $urandom_range(0, 3);
      model(r.w, r.se, r.sz, r.a, r.wd, r.rd, r.es, r.ewd, r.erd, r.mis);
      run32(r, $sformatf("rnd%0d", k));
    end
    // flush in DATA, new request waits through DRAIN
    rv = 1; rw = 0; rse = 0; rsz = 2; ra = 32'h10;
    tick;
    rv = 0; b32.addr_ok = 1;
    tick;
    b32.addr_ok = 0;
    #1;
    chk("t4 data req", b32.req, 0);
    flush = 1;
    #1;
    chk("t4 flush stall", stall, 0);
    tick;
    flush = 0; rv = 1; ra = 32'h20;
    #1;
    chk("t4 drain stall", stall, 1);
    chk("t4 drain req", b32.req, 0);
    chk("t4 drain done", done, 0);
    tick;
    b32.data_ok = 1; b32.rdata = 32'h5555_5555;
    #1;
    chk("t4 drain2 stall", stall, 1);
    chk("t4 drain2 done", done, 0);
    tick;
    b32.data_ok = 0;
    #1;
    chk("t4 idle done", done, 0);
    chk("t4 idle req", b32.req, 0);
    chk("t4 idle stall", stall, 1);
    tick;
    rv = 0;
    #1;
    chk("t4 issue req", b32.req, 1);
    chk("t4 issue addr", b32.addr, 32'h20);
    b32.addr_ok = 1; b32.data_ok = 1; b32.rdata = 32'hCAFE_F00D;
    tick;
    b32.addr_ok = 0; b32.data_ok = 0;
    #1;
    chk("t4 done", done, 1);
    chk("t4 rdata", rdo, 32'hCAFE_F00D);
    tick;
    // flush in ADDR without addr_ok withdraws the request
    rv = 1; rw = 1; rsz = 2; ra = 32'h40; rwd = 32'h1;
    tick;
    rv = 0;
    #1;
    chk("fa req", b32.req, 1);
    flush = 1;
    #1;
    chk("fa stall", stall, 0);
    tick;
    flush = 0;
    #1;
    chk("fa withdrawn", b32.req, 0);
    chk("fa done", done, 0);
    tick;
    chk("fa done2", done, 0);
    // flush with same-cycle addr_ok and data_ok returns straight to IDLE
    rv = 1; rw = 0; rsz = 0; ra = 32'h51;
    tick;
    rv = 0; flush = 1; b32.addr_ok = 1; b32.data_ok = 1;
    tick;
    flush = 0; b32.addr_ok = 0; b32.data_ok = 0;
    #1;
    chk("fc done", done, 0);
    rv = 1; ra = 32'h60;
    #1;
    chk("fc accept stall", stall, 1);
    tick;
    rv = 0;
    #1;
    chk("fc reissue req", b32.req, 1);
    b32.addr_ok = 1; b32.data_ok = 1; b32.rdata = 32'h0000_0077;
    tick;
    b32.addr_ok = 0; b32.data_ok = 0;
    #1;
    chk("fc done2", done, 1);
    chk("fc rdata", rdo, 32'h77);
    tick;
    // flush while idle blocks acceptance
    rv = 1; flush = 1;
    #1;
    chk("fi stall", stall, 0);
    tick;
    rv = 0; flush = 0;
    #1;
    chk("fi req", b32.req, 0);
    // 64-bit unit
    run64(0, 0, 2'd3, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, "d64 ld");
    run64(0, 1, 2'd2, 32'hC, 64'h0, 64'h8765_4321_0000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, "w64 ld");
    run64(1, 0, 2'd2, 32'hC, 64'h1122_3344, 64'h0, 8'hF0, 64'h1122_3344_0000_0000, 64'h0, "w64 st");
    v64 = 1; w64 = 0; sz64 = 3; a64 = 32'h4;
    #1;
    chk("d64 adel", adel64, 1);
    chk("d64 badv", badv64, 32'h4);
    chk("d64 mis stall", stall64, 0);
    a64 = 32'h10;
    tick;
    v64 = 0; b64.addr_ok = 1;
    tick;
    b64.addr_ok = 0;
    rst64 = 1;
    tick;
    rst64 = 0;
    #1;
    chk("r64 req", b64.req, 0);
    chk("r64 done", done64, 0);
    chk("r64 stall", stall64, 0);
    chk("r64 rdata", rdo64, 0);
    chk("r64 addr", b64.addr, 0);
    b64.data_ok = 1;
    tick;
    b64.data_ok = 0;
    chk("r64 done2", done64, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised multi-cycle load/store unit for the MEM stage of the pipeline.
- Replaces the single-cycle RAM strobe with a request/address-ok/data-ok bus handshake.
- Performs alignment, byte-strobe generation, load extraction and sign/zero extension internally.
- Stalls the pipeline until the access completes, detects AdEL/AdES, and drains in-flight bus transactions on flush.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, bus/register data width; legal values 32 or 64. LANES = DATA_WIDTH/8, OFS_W = log2(LANES).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill current MEM-stage instruction (exception/eret).
- req_valid_i  in  1  MEM-stage instruction is a load or store.
- req_write_i  in  1  1=store, 0=load.
- req_sign_ext_i  in  1  sign-extend load result.
- req_size_i  in  2  0 byte, 1 half, 2 word, 3 dword (DATA_WIDTH=64 only).
- req_addr_i  in  ADDR_WIDTH  effective address.
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned.
- stall_o  out  1  hold pipeline.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_WIDTH  extended load result, valid with done_o.
- adel_o, ades_o  out  1 each  misaligned load/store (combinational).
- badvaddr_o  out  ADDR_WIDTH  faulting address, else 0.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  write.
- bus_size_o  out  3  size code = req_size.
- bus_addr_o  out  ADDR_WIDTH  unmodified address.
- bus_wstrb_o  out  LANES  byte strobes.
- bus_wdata_o  out  DATA_WIDTH  lane-shifted store data.
- bus_addr_ok_i  in  1  address accepted.
- bus_data_ok_i  in  1  response (rdata or write ack).
- bus_rdata_i  in  DATA_WIDTH  raw read data.

Behaviour:
- Reset: state IDLE; all captured request registers, rdata_o, and every bus output 0; done_o 0.
- misaligned:
  - half with ofs[0] set.
  - word with ofs[1:0] != 0.
  - dword with ofs != 0.
  - Computed from req_* inputs. adel_o = req_valid_i & misaligned & !req_write_i. ades_o = the same with req_write_i. badvaddr_o = req_addr_i when either is high, else 0.
- IDLE:
  - Accept when req_valid_i & !flush & !misaligned. Latch the request, go to ADDR.
  - A misaligned request is never issued to the bus.
- ADDR:
  - bus_req_o = 1; bus_* driven from latched fields.
  - Hold all bus_* outputs stable until bus_addr_ok_i.
  - On addr_ok & data_ok in the same cycle: go to DONE. On addr_ok alone: go to DATA.
- DATA:
  - bus_req_o = 0. On bus_data_ok_i: latch extended rdata_o (loads only), go to DONE.
- DONE:
  - done_o = 1, stall_o = 0; the pipeline advances at this edge.
  - req_* inputs are ignored. Next state IDLE.
- Flush:
  - In ADDR without addr_ok: go to IDLE; the request is withdrawn.
  - In ADDR with addr_ok and without data_ok, or in DATA without data_ok: go to DRAIN.
  - When data_ok arrives in the flush cycle: go to IDLE.
  - done_o is never asserted for a flushed access.
  - Flush in DONE has no effect on state.
- DRAIN:
  - Wait for bus_data_ok_i, discard the data, go to IDLE. No new bus_req_o.
- stall_o:
  - 0 whenever flush = 1.
  - Otherwise 1 when: (IDLE & accept), ADDR, DATA, or (DRAIN & req_valid_i).
- Store lanes:
  - bus_wstrb_o = (size mask: 1/3/F/FF) << ofs.
  - bus_wdata_o = req_wdata_i << (8*ofs). Loads drive wstrb 0.
- Load extraction:
  - sh = bus_rdata_i >> (8*ofs), truncated to 8/16/32/64 bits.
  - Extended to DATA_WIDTH by the MSB when sign_ext, else zero-extended.
- req_size_i = 3 with DATA_WIDTH = 32 is never issued by decode; it is treated as word.
- Bus protocol: at most one outstanding transaction.

Decomposition:
- Shared include/mau.v: size codes (MAU_SIZE_B/H/W/D), state encodings (IDLE, ADDR, DATA, DONE, DRAIN), size-mask constants.
- One combinational sub-module, mau_align, holding the strobe/wdata shifter and the load extractor/extender. It is parametrised by DATA_WIDTH.
- The FSM lives in mem_access_unit.

Test Plan:
1. Load byte, addr 0x103, sign_ext, DW=32; bus_rdata 0x80000000; addr_ok cycle 1, data_ok cycle 3 → bus_size 0, wstrb 0; rdata_o 0xFFFFFF80 with done_o one cycle after data_ok; stall_o high from accept until DONE.
2. Store half, addr 0x202, wdata 0x0000ABCD → bus_wstrb 4'b1100, bus_wdata 0xABCD0000, bus_we 1; outputs held through 2 cycles of addr_ok low.
3. Load word at 0x1001 → adel_o 1, badvaddr_o 0x1001, bus_req_o never asserted, stall_o 0. Store word at 0x1002 → ades_o 1.
4. Flush in DATA one cycle after addr_ok, data_ok 2 cycles later → state DRAIN; no done_o. A new req_valid_i during DRAIN sees stall_o 1; it is issued the cycle after data_ok.
5. Same-cycle addr_ok & data_ok on load halfword unsigned, addr 0x2, rdata 0xF00D0000 → rdata_o 0x0000F00D.
6. DW=64, load dword at 0x8, plus rst asserted mid-DATA → first case returns full 64-bit data; after reset, state IDLE, bus_req_o 0, done_o 0.
